// File: rtl/ninjakun_cen_gen.sv
// ninjakun_cen_gen: NCH integer clock-enable dividers with an optional fractional-rate enable.
// The fractional accumulator is built only when NINJAKUN_CEN_GEN_FRAC_EN is defined.
module ninjakun_cen_gen #(
   parameter int NCH  = 4,
   parameter int DIVW = 8
) (
   input  logic                MCLK,
   input  logic                RESET,
   input  logic                HOLD,
   input  logic                SYNC,
   input  logic [NCH*DIVW-1:0] DIV,
   output logic [NCH-1:0]      CEN,
   output logic [NCH-1:0]      CENN,
   output logic [NCH-1:0]      CLKO,
   input  logic [15:0]         FRAC_N,
   input  logic [15:0]         FRAC_M,
   output logic                FRAC_CEN
);
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DIVW-1:0] d, de, cnt;
      logic wrap, fall, cen, cenn, clko;
      // effective ratio and phase decodes, taken from the live divide ratio
      always_comb begin
         d    = DIV[i*DIVW +: DIVW];
         de   = (d < DIVW'(2)) ? DIVW'(1) : d;
         wrap = cnt >= de - DIVW'(1);
         fall = (de >= DIVW'(2)) && (cnt == (de >> 1) - DIVW'(1));
      end
      // phase counter, registered enables and square clock; SYNC beats HOLD
      always_ff @(posedge MCLK or posedge RESET) begin
         if (RESET) begin
            cnt  <= '0;
            cen  <= 1'b0;
            cenn <= 1'b0;
            clko <= 1'b0;
         end else if (SYNC) begin
            cnt  <= '0;
            cen  <= 1'b0;
            cenn <= 1'b0;
            clko <= 1'b0;
         end else if (HOLD) begin
            cen  <= 1'b0;
            cenn <= 1'b0;
         end else begin
            cnt  <= wrap ? '0 : cnt + DIVW'(1);
            cen  <= wrap;
            cenn <= fall;
            clko <= wrap ? (de >= DIVW'(2)) : clko & ~fall;
         end
      end
      assign CEN[i]  = cen;
      assign CENN[i] = cenn;
      assign CLKO[i] = clko;
   end

`ifdef NINJAKUN_CEN_GEN_FRAC_EN
   logic [15:0] acc;
   logic [16:0] sum;
   logic sat, hit;
   // 17-bit sum so acc+N never overflows before the modulus compare
   always_comb begin
      sum = {1'b0, acc} + {1'b0, FRAC_N};
      sat = (FRAC_M == 16'd0) || (FRAC_N >= FRAC_M);
      hit = sum >= {1'b0, FRAC_M};
   end
   // fractional accumulator; a saturated ratio pulses every cycle with acc parked at 0
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         acc      <= '0;
         FRAC_CEN <= 1'b0;
      end else if (SYNC) begin
         acc      <= '0;
         FRAC_CEN <= 1'b0;
      end else if (HOLD) begin
         FRAC_CEN <= 1'b0;
      end else begin
         acc      <= sat ? '0 : hit ? 16'(sum - {1'b0, FRAC_M}) : sum[15:0];
         FRAC_CEN <= sat | hit;
      end
   end
`else
   logic unused_frac;
   assign unused_frac = ^{FRAC_N, FRAC_M};
   assign FRAC_CEN    = 1'b0;
`endif
endmodule

// File: tb/tb_ninjakun_cen_gen.sv
// tb_ninjakun_cen_gen: directed scoreboard bench for ninjakun_cen_gen
module tb_ninjakun_cen_gen;
   localparam int NCH  = 4;
   localparam int DIVW = 8;
   localparam int VW   = 3 * NCH + 1;
`ifdef NINJAKUN_CEN_GEN_FRAC_EN
   localparam bit FRAC_EN = 1'b1;
`else
   localparam bit FRAC_EN = 1'b0;
`endif

   logic MCLK = 1'b0, RESET = 1'b1, HOLD = 1'b0, SYNC = 1'b0;
   logic [NCH*DIVW-1:0] DIV = '0;
   logic [15:0] FRAC_N = '0, FRAC_M = '0;
   logic [NCH-1:0] CEN, CENN, CLKO;
   logic FRAC_CEN;

   int checks = 0, errors = 0;
   int n = 0;
   int d [NCH];
   int off [NCH];

   typedef struct {
      string         tag;
      logic [VW-1:0] exp;
   } item_t;
   item_t sb [$];

   ninjakun_cen_gen #(.NCH(NCH), .DIVW(DIVW)) dut (
      .MCLK(MCLK), .RESET(RESET), .HOLD(HOLD), .SYNC(SYNC), .DIV(DIV),
      .CEN(CEN), .CENN(CENN), .CLKO(CLKO),
      .FRAC_N(FRAC_N), .FRAC_M(FRAC_M), .FRAC_CEN(FRAC_CEN)
   );

   always #5 MCLK = ~MCLK;

   // fractional enable after k enabled edges from a cleared accumulator
   function automatic logic frac_exp(int k);
      int fn = int'(FRAC_N);
      int fm = int'(FRAC_M);
      if (!FRAC_EN || k <= 0) return 1'b0;
      if (fm == 0 || fn >= fm) return 1'b1;
      return (fn * k) / fm != (fn * (k - 1)) / fm;
   endfunction

   // expected {CEN,CENN,CLKO,FRAC_CEN} after the k-th enabled edge
   function automatic logic [VW-1:0] exp_vec(int k);
      logic [NCH-1:0] c, cn, ck;
      for (int i = 0; i < NCH; i++) begin
         int m = k + off[i];
         int p = m % d[i];
         c[i]  = (m > 0) && (p == 0);
         cn[i] = (d[i] >= 2) && (m > 0) && (p == d[i] / 2);
         ck[i] = (m >= d[i]) && (p < d[i] / 2);
      end
      return {c, cn, ck, frac_exp(k)};
   endfunction

   task automatic chk(input string tag, input logic [VW-1:0] exp);
      logic [VW-1:0] got;
      got = {CEN, CENN, CLKO, FRAC_CEN};
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s n=%0d got=%b exp=%b", tag, n, got, exp);
      end
   endtask

   task automatic set_div(input int a3, input int a2, input int a1, input int a0);
      int v [NCH];
      v = '{a0, a1, a2, a3};
      for (int i = 0; i < NCH; i++) begin
         DIV[i*DIVW +: DIVW] = DIVW'(v[i]);
         d[i]   = (v[i] < 2) ? 1 : v[i];
         off[i] = 0;
      end
   endtask

   task automatic do_reset(input string tag);
      item_t it;
      @(negedge MCLK);
      RESET = 1'b1;
      HOLD  = 1'b0;
      SYNC  = 1'b0;
      #1;
      chk({tag, "_async_rst"}, '0);
      @(posedge MCLK);
      @(negedge MCLK);
      sb.push_back('{{tag, "_rst_hold"}, '0});
      it = sb.pop_front();
      chk(it.tag, it.exp);
      RESET = 1'b0;
      n = 0;
   endtask

   // drive one edge's controls, predict, clock it, then compare the scoreboard head
   task automatic step(input string tag, input logic h, input logic s, input int cycles);
      item_t it;
      logic [VW-1:0] e;
      for (int j = 0; j < cycles; j++) begin
         HOLD = h;
         SYNC = s;
         if (s) begin
            n = 0;
            e = '0;
         end else if (h) begin
            e = exp_vec(n);
            e = {{(2*NCH){1'b0}}, e[NCH:1], 1'b0};
         end else begin
            n++;
            e = exp_vec(n);
         end
         sb.push_back('{tag, e});
         @(posedge MCLK);
         @(negedge MCLK);
         it = sb.pop_front();
         chk(it.tag, it.exp);
      end
      HOLD = 1'b0;
      SYNC = 1'b0;
   endtask

   initial begin
      // base ratios, fraction 3/8
      FRAC_N = 16'd3;
      FRAC_M = 16'd8;
      set_div(16, 8, 4, 2);
      do_reset("base");
      step("base", 1'b0, 1'b0, 40);

      // odd ratio, ratios 0 and 1, fraction above modulus
      FRAC_N = 16'd9;
      FRAC_M = 16'd8;
      set_div(3, 1, 0, 5);
      do_reset("odd");
      step("odd", 1'b0, 1'b0, 20);

      // hold for three cycles at cnt=3, zero modulus
      FRAC_N = 16'd5;
      FRAC_M = 16'd0;
      set_div(16, 4, 2, 8);
      do_reset("hold");
      step("hold_pre", 1'b0, 1'b0, 3);
      step("hold_on", 1'b1, 1'b0, 3);
      step("hold_post", 1'b0, 1'b0, 14);

      // sync on a wrap edge, then sync together with hold
      FRAC_N = 16'd3;
      FRAC_M = 16'd8;
      set_div(16, 8, 4, 2);
      do_reset("sync");
      step("sync_pre", 1'b0, 1'b0, 7);
      step("sync_wrap", 1'b0, 1'b1, 1);
      step("sync_mid", 1'b0, 1'b0, 3);
      step("sync_hold", 1'b1, 1'b1, 1);
      step("sync_post", 1'b0, 1'b0, 20);

      // ratio 8 -> 3 while cnt=6 forces an immediate wrap
      set_div(16, 4, 2, 8);
      do_reset("div");
      step("div_pre", 1'b0, 1'b0, 6);
      DIV[DIVW-1:0] = 8'd3;
      d[0]   = 3;
      off[0] = -4;
      step("div_post", 1'b0, 1'b0, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ninjakun_cen_gen.md
NINJAKUN_CEN_GEN -- requirements
Module: ninjakun_cen_gen

Interface
REQ-001 SHALL have parameter NCH, default 4: number of integer divider channels (1..16).
REQ-002 SHALL have parameter DIVW, default 8: width of each channel divide ratio.
REQ-003 SHALL have port MCLK  in  1  master clock, 48 MHz; sole clock.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port HOLD  in  1  freezes all dividers (pause).
REQ-006 SHALL have port SYNC  in  1  realigns all dividers to phase 0.
REQ-007 SHALL have port DIV  in  NCH*DIVW  divide ratio D[i] in bits [i*DIVW +: DIVW].
REQ-008 SHALL have port CEN  out  NCH  one-cycle rising-phase clock enables.
REQ-009 SHALL have port CENN  out  NCH  one-cycle falling-phase clock enables.
REQ-010 SHALL have port CLKO  out  NCH  registered ~50% square clocks.
REQ-011 SHALL have port FRAC_N  in  16  fractional numerator.
REQ-012 SHALL have port FRAC_M  in  16  fractional modulus.
REQ-013 SHALL have port FRAC_CEN  out  1  fractional-rate clock enable.

Function
REQ-014 SHALL treat effective ratio De[i] as D[i], except 1 when D[i] is 0 or 1.
REQ-015 SHALL keep counter cnt[i] (DIVW bits); per edge without HOLD/SYNC: if cnt[i] >= De[i]-1 then 0, else cnt[i]+1.
REQ-016 SHALL register CEN[i] high for exactly the cycle after an edge where cnt[i] wrapped; first pulse follows the De-th rising edge after RESET release, then every De edges.
REQ-017 SHALL register CENN[i] high for the cycle after an edge where cnt[i] == floor(De/2)-1; CENN[i] stays 0 when De < 2.
REQ-018 SHALL set CLKO[i] to 1 on the edge asserting CEN[i] and to 0 on the edge asserting CENN[i]; CLKO[i] stays 0 when De < 2.
REQ-019 SHALL use DIV live each cycle; a change takes effect at the next comparison, and the >= rule forces an immediate wrap when cnt exceeds the new De-1.
REQ-020 SHALL, while HOLD=1, freeze all counters, CLKO and the accumulator, and drive CEN, CENN and FRAC_CEN to 0 from the next edge.
REQ-021 SHALL, while SYNC=1, clear all counters, the accumulator, CEN, CENN, CLKO and FRAC_CEN; SYNC overrides HOLD and an coincident wrap (no pulse).
REQ-022 SHALL keep a 16-bit accumulator acc; per enabled edge: if acc+FRAC_N >= FRAC_M then acc <= acc+FRAC_N-FRAC_M and FRAC_CEN <= 1, else acc <= acc+FRAC_N and FRAC_CEN <= 0; the sum SHALL be computed at 17 bits.
REQ-023 SHALL, when FRAC_M == 0 or FRAC_N >= FRAC_M, pulse FRAC_CEN every enabled cycle and hold acc at 0.
REQ-024 SHALL produce no combinational path from any input to any output.

Reset
REQ-025 SHALL on RESET=1 asynchronously clear all cnt, acc, CEN, CENN, CLKO and FRAC_CEN to 0.
REQ-026 SHALL resume counting on the first MCLK rising edge after RESET deasserts.

Configuration
REQ-027 SHALL compile the fractional accumulator only when macro NINJAKUN_CEN_GEN_FRAC_EN is defined.
REQ-028 SHALL, without NINJAKUN_CEN_GEN_FRAC_EN, keep FRAC_N/FRAC_M ports, ignore them, tie FRAC_CEN to 0, and contain no accumulator logic.

Verification
REQ-029 SHALL verify: DIV={16,8,4,2} (ch3..ch0) after reset -> CEN0 every 2 edges (24 MHz), CEN1 every 4, CEN2 every 8, CEN3 every 16 with CLKO3 8 high / 8 low.
REQ-030 SHALL verify: D=5 -> CEN at edges 5,10,15; CENN at edges 2,7,12; CLKO 2 cycles high, 3 low.
REQ-031 SHALL verify: D=8, HOLD high for 3 cycles at cnt=3 -> next CEN delayed by exactly 3 cycles, no pulse while held.
REQ-032 SHALL verify: SYNC asserted on a wrap edge -> no CEN; next CEN exactly De edges after SYNC deasserts, all channels aligned.
REQ-033 SHALL verify: D changed 8->3 while cnt=6 -> wrap and CEN on next edge, then period 3.
REQ-034 SHALL verify: FRAC_EN defined, N=3, M=8 -> exactly 3 FRAC_CEN pulses per 8 cycles, repeating; N=9, M=8 -> pulse every cycle; macro undefined -> FRAC_CEN constantly 0.
